// File: rtl/y86_dmem_responder.sv
// ============================================================================
// Module   : y86_dmem_responder
// Purpose  : Data-memory responder for the Y86-64 memory stage. Accepts one
//            8-byte read or write request over a valid/ready handshake, waits
//            a programmable latency, then returns little-endian read data and
//            an out-of-range error flag over a second valid/ready handshake.
// Ports    : clk, rst_n (async active-low)
//            i_req_valid/o_req_ready, i_req_write, i_req_addr[63:0],
//            i_req_wdata[63:0]                                  - request
//            o_rsp_valid/i_rsp_ready, o_rsp_rdata[63:0],
//            o_rsp_error                                        - response
//            o_rd_count[31:0], o_wr_count[31:0]   - only with DMEM_PERF_CNT_EN
// Options  : DMEM_PERF_CNT_EN - adds completed read/write counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_dmem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [63:0] o_rsp_rdata,
    output logic        o_rsp_error
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] o_rd_count,
    output logic [31:0] o_wr_count
`endif
);

    localparam int          c_AW       = $clog2(MEM_BYTES);
    localparam logic [63:0] c_MAX_ADDR = 64'(MEM_BYTES - 8);
    localparam logic [3:0]  c_LAT      = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rsp_rdata;
    logic        r_rsp_error;

    logic [7:0]  r_mem [MEM_BYTES];

    logic             w_accept;
    logic             w_done_wait;
    logic             w_rsp_hs;
    logic             w_addr_err;
    logic             w_commit_wr;
    logic [c_AW-1:0]  w_base;
    logic [63:0]      w_rd_word;

    assign w_accept    = i_req_valid && (r_state == S_IDLE);
    // Last WAIT cycle: this edge moves to RESP, commits writes, samples reads.
    assign w_done_wait = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_rsp_hs    = (r_state == S_RESP) && i_rsp_ready;
    // Full 64-bit compare so addresses near 2^64 cannot wrap into range.
    assign w_addr_err  = (r_addr > c_MAX_ADDR);
    // rst_n gates the store so a clock edge during reset cannot commit.
    assign w_commit_wr = w_done_wait && r_write && !w_addr_err && rst_n;
    assign w_base      = r_addr[c_AW-1:0];

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                // Even LATENCY=0 passes through one WAIT cycle so the
                // response appears LATENCY+1 edges after the accept edge.
                if (i_req_valid) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 64'd0;
            r_wdata     <= 64'd0;
            r_rsp_rdata <= 64'd0;
            r_rsp_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= c_LAT;
                r_write <= i_req_write;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_done_wait) begin
                r_rsp_rdata <= (r_write || w_addr_err) ? 64'd0 : w_rd_word;
                r_rsp_error <= w_addr_err;
            end else if (w_rsp_hs) begin
                r_rsp_rdata <= 64'd0;
                r_rsp_error <= 1'b0;
            end
        end
    end

    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_error = r_rsp_error;

    // ------------------------------------------------------------------
    // Byte store (contents intentionally survive reset)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_word = 64'd0;
        for (int i = 0; i < 8; i++) begin
            w_rd_word[8*i +: 8] = r_mem[w_base + c_AW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[w_base + c_AW'(i)] <= r_wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Completed-transaction counters (non-error only, wrap naturally)
    // ------------------------------------------------------------------
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= 32'd0;
            r_wr_count <= 32'd0;
        end else if (w_rsp_hs && !r_rsp_error) begin
            if (r_write) begin
                r_wr_count <= r_wr_count + 32'd1;
            end else begin
                r_rd_count <= r_rd_count + 32'd1;
            end
        end
    end

    assign o_rd_count = r_rd_count;
    assign o_wr_count = r_wr_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_y86_dmem_responder.sv
// ============================================================================
// Module   : tb_y86_dmem_responder
// Purpose  : Self-checking bench for y86_dmem_responder. Driver pushes the
//            expected response into a queue; a monitor pops and compares on
//            every response handshake. A second instance with LATENCY=0
//            checks the minimum-latency path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_y86_dmem_responder;

    localparam int MB  = 1024;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
    logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
    logic        req_ready, rsp_valid, rsp_error;
    logic [63:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_rsp_ready = 1'b1;
    logic [63:0] z_req_addr = 64'd0, z_req_wdata = 64'd0;
    logic        z_req_ready, z_rsp_valid, z_rsp_error;
    logic [63:0] z_rsp_rdata;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_count, wr_count, z_rd_count, z_wr_count;
`endif

    always #5 clk = ~clk;

    y86_dmem_responder #(.MEM_BYTES(MB), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error)
`ifdef DMEM_PERF_CNT_EN
        , .o_rd_count(rd_count), .o_wr_count(wr_count)
`endif
    );

    y86_dmem_responder #(.MEM_BYTES(MB), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(z_req_valid), .o_req_ready(z_req_ready),
        .i_req_write(z_req_write), .i_req_addr(z_req_addr), .i_req_wdata(z_req_wdata),
        .o_rsp_valid(z_rsp_valid), .i_rsp_ready(z_rsp_ready),
        .o_rsp_rdata(z_rsp_rdata), .o_rsp_error(z_rsp_error)
`ifdef DMEM_PERF_CNT_EN
        , .o_rd_count(z_rd_count), .o_wr_count(z_wr_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_rd   = 0;
    int exp_wr   = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [63:0] D0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] D1 = 64'h1122334455667788;
    localparam logic [63:0] D2 = 64'h0F1E2D3C4B5A6978;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: compare at the negedge preceding each handshake edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_rdata"}, rsp_rdata, e.rdata);
                check({e.name, "_err"}, {63'd0, rsp_error}, {63'd0, e.err});
            end
        end
    end

    // Issue one request on the main DUT, check its latency, wait for its response.
    task automatic do_req(input string name, input logic wr, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] exp_rdata,
                          input logic exp_err);
        logic acc;
        int   lat;
        exp_q.push_back('{rdata: exp_rdata, err: exp_err, name: name});
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = req_ready;
            @(posedge clk); #1;
        end
        check({name, "_accept"}, {63'd0, acc}, 64'd1);
        // Scramble request lines: latched values must be the ones used.
        req_valid = 1'b0; req_write = ~wr;
        req_addr  = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(LAT + 1));
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        if (!exp_err) begin
            if (wr) exp_wr++; else exp_rd++;
        end
    endtask

    // LATENCY=0 instance: direct checks on response timing and data.
    task automatic do_req0(input string name, input logic wr, input logic [63:0] a,
                           input logic [63:0] d, input logic [63:0] exp_rdata);
        int lat;
        z_req_valid = 1'b1; z_req_write = wr; z_req_addr = a; z_req_wdata = d;
        check({name, "_ready"}, {63'd0, z_req_ready}, 64'd1);
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        lat = 0;
        while (!z_rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd1);
        check({name, "_rdata"}, z_rsp_rdata, exp_rdata);
        check({name, "_err"}, {63'd0, z_rsp_error}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {63'd0, req_ready}, 64'd1);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_rsp_error", {63'd0, rsp_error}, 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write/read, unaligned read spanning two words.
        do_req("wr_10", 1'b1, 64'h10, D0, 64'd0, 1'b0);
        do_req("wr_18", 1'b1, 64'h18, D1, 64'd0, 1'b0);
        do_req("rd_10", 1'b0, 64'h10, 64'd0, D0, 1'b0);
        do_req("rd_11", 1'b0, 64'h11, 64'd0, 64'h880123456789ABCD, 1'b0);

        // Range boundary and error handling.
        do_req("wr_top", 1'b1, 64'(MB - 8), D2, 64'd0, 1'b0);
        do_req("rd_top", 1'b0, 64'(MB - 8), 64'd0, D2, 1'b0);
        do_req("rd_top_p1", 1'b0, 64'(MB - 7), 64'd0, 64'd0, 1'b1);
        do_req("rd_wrap", 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd0, 64'd0, 1'b1);
        do_req("wr_err1", 1'b1, 64'(MB - 7), 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        do_req("wr_err2", 1'b1, 64'hFFFFFFFFFFFFFBF8, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        do_req("rd_top_again", 1'b0, 64'(MB - 8), 64'd0, D2, 1'b0);

        // Async reset in the middle of a write's WAIT phase.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'hDEADBEEFCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midwait_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("midwait_rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("midwait_rst_rsp_error", {63'd0, rsp_error}, 64'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        exp_rd = 0; exp_wr = 0;
        @(posedge clk); #1;
        do_req("rd_after_rst", 1'b0, 64'h10, 64'd0, D0, 1'b0);

        // Backpressure: response held stable, req_* activity ignored.
        rsp_ready = 1'b0;
        exp_q.push_back('{rdata: D0, err: 1'b0, name: "bp"});
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 64'h18; req_wdata = 64'hFFFFFFFFFFFFFFFF;
        for (int k = 0; k < 20 && !rsp_valid; k++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_rsp_rdata", rsp_rdata, D0);
            check("bp_req_ready", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        // Release with a new request already valid: it must wait for IDLE.
        exp_q.push_back('{rdata: 64'h880123456789ABCD, err: 1'b0, name: "post_bp"});
        req_write = 1'b0; req_addr = 64'h11; rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_no_accept", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("post_bp_drained", 64'(exp_q.size()), 64'd0);
        exp_rd += 2;

        do_req("wr_30", 1'b1, 64'h30, D1, 64'd0, 1'b0);
        do_req("rd_30", 1'b0, 64'h30, 64'd0, D1, 1'b0);
        do_req("rd_err", 1'b0, 64'(MB), 64'd0, 64'd0, 1'b1);

        // Minimum latency instance.
        do_req0("l0_wr", 1'b1, 64'h20, D2, 64'd0);
        do_req0("l0_rd", 1'b0, 64'h20, 64'd0, D2);

`ifdef DMEM_PERF_CNT_EN
        check("rd_count", 64'(rd_count), 64'(exp_rd));
        check("wr_count", 64'(wr_count), 64'(exp_wr));
        check("l0_rd_count", 64'(z_rd_count), 64'd1);
        check("l0_wr_count", 64'(z_wr_count), 64'd1);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
